// File: rtl/i2c_master_if.sv
// Request/status bundle between the I2C master and its host.
// The open-drain sda line stays a plain port on the master.
interface i2c_master_if;
   logic       start;
   logic       stop;
   logic       rd_wr_en;
   logic [6:0] w_addr;
   logic [7:0] w_data;
   logic       scl;
   logic [7:0] r_data;
   logic       busy;
   logic       ack_err;

   modport master (
      input  start, stop, rd_wr_en, w_addr, w_data,
      output scl, r_data, busy, ack_err
   );

   modport slave (
      output start, stop, rd_wr_en, w_addr, w_data,
      input  scl, r_data, busy, ack_err
   );
endinterface

// File: rtl/i2c_master.sv
// Single-master I2C engine: START, address+R/W, ACK, byte stream, STOP.
// One SCL bit is four ticks of DIV clocks; scl/sda/busy are registered from the FSM state.
module i2c_master #(
   parameter int DIV = 1
) (
   input  logic         clk,
   input  logic         reset,
   i2c_master_if.master bus,
   inout  wire          sda
);

   localparam int            DW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_M1 = DW'(DIV - 1);

   typedef enum logic [2:0] {IDLE, START, ADDR, ACK_A, DATA, ACK_D, STOP} state_t;

   state_t        r_state;
   logic [DW-1:0] r_div;
   logic [1:0]    r_q;
   logic [2:0]    r_bit;
   logic [7:0]    r_tx;
   logic [7:0]    r_rx;
   logic [7:0]    r_data;
   logic          r_rw;
   logic          r_stop_pend;
   logic          r_nack;
   logic          r_ack_err;
   logic          r_busy;
   logic          r_scl;
   logic          r_sda_oe;

   logic          w_tick_end;
   logic          w_bit_end;
   logic          w_smp;
   logic          w_sda_in;
   logic          w_scl;
   logic          w_sda_oe;
   logic [7:0]    w_rx_nxt;

   assign sda      = r_sda_oe ? 1'b0 : 1'bz;
   assign w_sda_in = sda;

   assign bus.scl     = r_scl;
   assign bus.r_data  = r_data;
   assign bus.busy    = r_busy;
   assign bus.ack_err = r_ack_err;

   assign w_tick_end = (r_div == DIV_M1);
   assign w_bit_end  = w_tick_end && (r_q == 2'd3);
   // Outputs lag the state by one clock, so the end of output tick 2 is the first cycle of state tick 3.
   assign w_smp      = (r_q == 2'd3) && (r_div == '0);
   assign w_rx_nxt   = w_smp ? {r_rx[6:0], w_sda_in} : r_rx;

   always_comb begin
      w_scl    = r_q[1];
      w_sda_oe = 1'b0;
      case (r_state)
         IDLE:    w_scl = 1'b1;
         START: begin
            w_scl    = 1'b1;
            w_sda_oe = r_q[1];
         end
         ADDR:    w_sda_oe = ~r_tx[7];
         DATA:    w_sda_oe = ~r_rw & ~r_tx[7];
         ACK_D:   w_sda_oe = r_rw & ~r_nack;
         STOP:    w_sda_oe = (r_q != 2'd3);
         default: w_sda_oe = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_div       <= '0;
         r_q         <= '0;
         r_bit       <= '0;
         r_tx        <= '0;
         r_rx        <= '0;
         r_data      <= '0;
         r_rw        <= 1'b0;
         r_stop_pend <= 1'b0;
         r_nack      <= 1'b0;
         r_ack_err   <= 1'b0;
         r_busy      <= 1'b0;
         r_scl       <= 1'b1;
         r_sda_oe    <= 1'b0;
      end else begin
         r_scl    <= w_scl;
         r_sda_oe <= w_sda_oe;
         r_busy   <= (r_state != IDLE);

         if (r_state == IDLE) begin
            r_div <= '0;
            r_q   <= '0;
         end else begin
            r_div <= w_tick_end ? '0 : r_div + 1'b1;
            if (w_tick_end) r_q <= r_q + 2'd1;
         end

         if (bus.stop && r_state != IDLE) r_stop_pend <= 1'b1;

         case (r_state)
            IDLE: if (bus.start) begin
               r_state     <= START;
               r_rw        <= bus.rd_wr_en;
               r_tx        <= {bus.w_addr, bus.rd_wr_en};
               r_ack_err   <= 1'b0;
               r_stop_pend <= 1'b0;
            end
            START: if (w_bit_end) begin
               r_state <= ADDR;
               r_bit   <= 3'd7;
            end
            ADDR: if (w_bit_end) begin
               r_tx <= {r_tx[6:0], 1'b0};
               if (r_bit == 3'd0) r_state <= ACK_A;
               else               r_bit   <= r_bit - 3'd1;
            end
            ACK_A: begin
               if (w_smp && w_sda_in) r_ack_err <= 1'b1;
               if (w_bit_end) begin
                  r_state <= DATA;
                  r_bit   <= 3'd7;
                  r_tx    <= bus.w_data;
               end
            end
            DATA: begin
               if (r_rw) r_rx <= w_rx_nxt;
               if (w_bit_end) begin
                  r_tx <= {r_tx[6:0], 1'b0};
                  if (r_bit == 3'd0) begin
                     r_state <= ACK_D;
                     // Freeze the ACK/NACK choice for the whole slot so SDA never moves under SCL high.
                     r_nack  <= r_stop_pend;
                     if (r_rw) r_data <= w_rx_nxt;
                  end else begin
                     r_bit <= r_bit - 3'd1;
                  end
               end
            end
            ACK_D: begin
               if (w_smp && !r_rw && w_sda_in) r_ack_err <= 1'b1;
               if (w_bit_end) begin
                  if (r_stop_pend) begin
                     r_state <= STOP;
                  end else begin
                     r_state <= DATA;
                     r_bit   <= 3'd7;
                     r_tx    <= bus.w_data;
                  end
               end
            end
            STOP: if (w_bit_end) begin
               r_state     <= IDLE;
               r_stop_pend <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master (DIV=1): a bus monitor records START/STOP/bit events,
// a scripted slave answers ACK/read data, and each transaction is scored against a queue.
module tb_i2c_master;

   logic clk;
   logic reset;
   wire  sda;

   i2c_master_if ifc ();

   i2c_master #(.DIV(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc),
      .sda   (sda)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave side of the open-drain line.
   logic slv_low;
   pullup (sda);
   assign sda = slv_low ? 1'b0 : 1'bz;

   int         n_vec;
   int         n_err;
   int         exp_q[$];
   int         obs_q[$];
   logic       mon_en;
   logic       slv_en;
   logic       slv_ack;
   logic       slv_rd;
   logic [7:0] slv_byte;
   logic       slv_done;
   int         k;
   logic       scl_p;
   logic       sda_p;
   logic       line;

   function automatic logic slv_drv(input int kk);
      int j;
      if (!slv_en || slv_done || kk < 8) return 1'b0;
      if (kk == 8) return slv_ack;
      j = (kk - 9) % 9;
      if (j == 8) return !slv_rd && slv_ack;
      return slv_rd && !slv_byte[7-j];
   endfunction

   // Events: 2 = START, 3 = STOP, 0/1 = sda seen at an SCL rising edge.
   always @(negedge clk) begin
      line = sda;
      if (mon_en) begin
         if (scl_p && ifc.scl && sda_p && !line) begin
            obs_q.push_back(2);
            k        = 0;
            slv_done = 1'b0;
         end else if (scl_p && ifc.scl && !sda_p && line) begin
            obs_q.push_back(3);
         end else if (!scl_p && ifc.scl) begin
            obs_q.push_back(int'(line));
            if (slv_rd && k >= 9 && (k - 9) % 9 == 8 && line) slv_done = 1'b1;
            k++;
         end else if (scl_p && !ifc.scl) begin
            slv_low = slv_drv(k);
         end
      end
      scl_p = ifc.scl;
      sda_p = line;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic void push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) exp_q.push_back(int'(b[i]));
   endfunction

   // STOP bit: SCL rises with SDA low (seen as a 0 bit), then SDA rises.
   function automatic void push_stop();
      exp_q.push_back(0);
      exp_q.push_back(3);
   endfunction

   task automatic score(input string tag);
      int n;
      chk({tag, "_nevents"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
      obs_q.delete();
      exp_q.delete();
   endtask

   // Starts a transaction and runs until busy drops (bounded), applying mid-transfer stimulus.
   task automatic run_txn(input string tag, input int stop_at, input int restart_at,
                          input int ae_at1, input int ae_exp1,
                          input int ae_at2, input int ae_exp2, input int lat_exp);
      int   c;
      logic done;
      obs_q.delete();
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      c    = 0;
      done = 1'b0;
      while (!done && c < 2000) begin
         @(posedge clk); #1;
         c++;
         ifc.stop = (c >= stop_at && c < stop_at + 10);
         if (c == restart_at) begin
            ifc.start    = 1'b1;
            ifc.w_addr   = 7'h7F;
            ifc.rd_wr_en = ~ifc.rd_wr_en;
         end else begin
            ifc.start = 1'b0;
         end
         if (c == ae_at1) chk({tag, "_ackerr_a"}, int'(ifc.ack_err), ae_exp1);
         if (c == ae_at2) chk({tag, "_ackerr_b"}, int'(ifc.ack_err), ae_exp2);
         if (c > 2 && !ifc.busy) done = 1'b1;
      end
      ifc.stop = 1'b0;
      chk({tag, "_latency"}, c, lat_exp);
      chk({tag, "_idle_scl"}, int'(ifc.scl), 1);
      chk({tag, "_idle_sda"}, int'(sda), 1);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      mon_en = 1'b0; slv_en = 1'b0; slv_ack = 1'b0; slv_rd = 1'b0;
      slv_byte = 8'h00; slv_done = 1'b0; slv_low = 1'b0; k = 0;
      scl_p = 1'b1; sda_p = 1'b1; line = 1'b1;
      reset = 1'b1;
      ifc.start = 1'b0; ifc.stop = 1'b0; ifc.rd_wr_en = 1'b0;
      ifc.w_addr = 7'h00; ifc.w_data = 8'h00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_scl", int'(ifc.scl), 1);
      chk("rst_sda", int'(sda), 1);
      chk("rst_busy", int'(ifc.busy), 0);
      chk("rst_ackerr", int'(ifc.ack_err), 0);
      chk("rst_rdata", int'(ifc.r_data), 0);

      // stop in IDLE must not start anything
      ifc.stop = 1'b1;
      repeat (3) @(posedge clk);
      #1 ifc.stop = 1'b0;
      chk("idle_stop_busy", int'(ifc.busy), 0);
      mon_en = 1'b1;

      // Write 0x15/0x36 with ACKing slave; stop mid-address, start retried while busy.
      slv_en = 1'b1; slv_ack = 1'b1; slv_rd = 1'b0;
      ifc.w_addr = 7'h15; ifc.rd_wr_en = 1'b0; ifc.w_data = 8'h36;
      exp_q.push_back(2);
      push_byte(8'h2A);
      exp_q.push_back(0);
      push_byte(8'h36);
      exp_q.push_back(0);
      push_stop();
      run_txn("wr1", 20, 30, 60, 0, -1, 0, 81);
      score("wr1");
      ifc.w_addr = 7'h15; ifc.rd_wr_en = 1'b0;

      // No slave: ack_err after ACK_A, 0x36 repeats until the stop at ~175 clks (4 bytes).
      slv_en = 1'b0;
      exp_q.push_back(2);
      push_byte(8'h2A);
      exp_q.push_back(1);
      for (int b = 0; b < 4; b++) begin
         push_byte(8'h36);
         exp_q.push_back(1);
      end
      push_stop();
      run_txn("wr4", 175, -1, 30, 0, 50, 1, 189);
      score("wr4");
      chk("wr4_ackerr_sticky", int'(ifc.ack_err), 1);

      // Read 0xA5 from slave 0x2A; stop during the byte -> NACK then STOP.
      slv_en = 1'b1; slv_ack = 1'b1; slv_rd = 1'b1; slv_byte = 8'hA5;
      ifc.w_addr = 7'h2A; ifc.rd_wr_en = 1'b1;
      exp_q.push_back(2);
      push_byte(8'h55);
      exp_q.push_back(0);
      push_byte(8'hA5);
      exp_q.push_back(1);
      push_stop();
      run_txn("rd", 50, -1, 5, 0, 60, 0, 81);
      score("rd");
      chk("rd_rdata", int'(ifc.r_data), 8'hA5);

      // Reset during ADDR: immediate IDLE, everything cleared, bus stays quiet.
      mon_en = 1'b0; slv_en = 1'b0; slv_low = 1'b0;
      ifc.rd_wr_en = 1'b0;
      ifc.start = 1'b1;
      @(posedge clk); #1;
      ifc.start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("mid_busy", int'(ifc.busy), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mrst_busy", int'(ifc.busy), 0);
      chk("mrst_scl", int'(ifc.scl), 1);
      chk("mrst_sda", int'(sda), 1);
      chk("mrst_rdata", int'(ifc.r_data), 0);
      repeat (40) @(posedge clk);
      #1;
      chk("mrst_quiet_busy", int'(ifc.busy), 0);
      chk("mrst_quiet_scl", int'(ifc.scl), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
